// File: rtl/input_debouncer_if.sv
// input_debouncer_if: raw input and debounced outputs of input_debouncer
interface input_debouncer_if #(
    parameter int EVT_W = 8
);
    logic             din;
    logic             d;
    logic             rise;
    logic             fall;
    logic [EVT_W-1:0] evt_cnt;
    modport master (output din, input d, rise, fall, evt_cnt);
    modport slave  (input din, output d, rise, fall, evt_cnt);
endinterface

// File: rtl/input_debouncer.sv
// input_debouncer: two-flop synchronizer, debounce FSM and rising-event counter
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3,
    parameter int EVT_W           = 8
) (
    input  logic               clk,
    input  logic               rst,
    input_debouncer_if.slave   bus
);
    typedef enum logic [1:0] {LOW, WAIT_HIGH, HIGH, WAIT_LOW} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    state_t           state, nxt_state;
    logic             s1, s2;
    logic [CNT_W-1:0] cnt, nxt_cnt;
    logic             d_q, rise_q, fall_q;
    logic             nxt_d, nxt_rise, nxt_fall;
    logic [EVT_W-1:0] evt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= bus.din;
            s2 <= s1;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= LOW;
            cnt    <= '0;
            d_q    <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            evt_q  <= '0;
        end else begin
            state  <= nxt_state;
            cnt    <= nxt_cnt;
            d_q    <= nxt_d;
            rise_q <= nxt_rise;
            fall_q <= nxt_fall;
            evt_q  <= nxt_rise ? evt_q + EVT_W'(1) : evt_q;
        end
    end
    always_comb begin
        nxt_state = state;
        nxt_cnt   = '0;
        nxt_d     = d_q;
        nxt_rise  = 1'b0;
        nxt_fall  = 1'b0;
        case (state)
            LOW: begin
                nxt_state = s2 ? WAIT_HIGH : LOW;
                nxt_cnt   = s2 ? ONE : '0;
            end
            WAIT_HIGH: begin
                if (!s2) begin
                    nxt_state = LOW;
                end else if (cnt == LAST) begin
                    nxt_state = HIGH;
                    nxt_d     = 1'b1;
                    nxt_rise  = 1'b1;
                end else begin
                    nxt_cnt = cnt + ONE;
                end
            end
            HIGH: begin
                nxt_state = s2 ? HIGH : WAIT_LOW;
                nxt_cnt   = s2 ? '0 : ONE;
            end
            default: begin
                if (s2) begin
                    nxt_state = HIGH;
                end else if (cnt == LAST) begin
                    nxt_state = LOW;
                    nxt_d     = 1'b0;
                    nxt_fall  = 1'b1;
                end else begin
                    nxt_cnt = cnt + ONE;
                end
            end
        endcase
    end
    assign bus.d       = d_q;
    assign bus.rise    = rise_q;
    assign bus.fall    = fall_q;
    assign bus.evt_cnt = evt_q;
endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: scoreboard bench; expected pulses queued at stimulus time, popped when the DUT pulses
module tb_input_debouncer;
    typedef struct {
        int         cyc;
        logic       r;
        logic [7:0] evt;
    } ev_t;
    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    int   rise2_n;
    int   fall2_n;
    ev_t  q1[$];
    ev_t  q2[$];
    ev_t  e1;
    ev_t  e2;
    input_debouncer_if #(.EVT_W(8)) if1 ();
    input_debouncer_if #(.EVT_W(2)) if2 ();
    input_debouncer #(.DEBOUNCE_CYCLES(4), .CNT_W(3), .EVT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    input_debouncer #(.DEBOUNCE_CYCLES(4), .CNT_W(3), .EVT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d at cycle %0d", tag, got, exp, cyc);
        end
    endtask
    task automatic drive(input logic v);
        @(negedge clk);
        if1.din = v;
    endtask
    task automatic expect1(input logic r, input logic [7:0] evt);
        q1.push_back('{cyc: cyc + 6, r: r, evt: evt});
    endtask
    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (!rst && (if1.rise || if1.fall)) begin
            if (q1.size() == 0) begin
                check("unexpected_pulse", {30'd0, if1.rise, if1.fall}, 32'd0);
            end else begin
                e1 = q1.pop_front();
                check("pulse_cycle", cyc, e1.cyc);
                check("pulse_kind", {30'd0, if1.rise, if1.fall}, e1.r ? 32'd2 : 32'd1);
                check("pulse_evt", {24'd0, if1.evt_cnt}, {24'd0, e1.evt});
                check("pulse_d", {31'd0, if1.d}, {31'd0, e1.r});
            end
        end
    end
    always @(negedge clk) begin
        if (!rst && (if2.rise || if2.fall)) begin
            rise2_n += int'(if2.rise);
            fall2_n += int'(if2.fall);
            if (q2.size() == 0) begin
                check("wrap_unexpected", {30'd0, if2.rise, if2.fall}, 32'd0);
            end else begin
                e2 = q2.pop_front();
                check("wrap_cycle", cyc, e2.cyc);
                check("wrap_kind", {30'd0, if2.rise, if2.fall}, e2.r ? 32'd2 : 32'd1);
                check("wrap_evt", {30'd0, if2.evt_cnt}, {24'd0, e2.evt});
            end
        end
    end
    initial begin
        cyc = 0; checks = 0; errors = 0; rise2_n = 0; fall2_n = 0;
        rst = 1'b1;
        if1.din = 1'b1;
        if2.din = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_d", {31'd0, if1.d}, 32'd0);
            check("rst_rise", {31'd0, if1.rise}, 32'd0);
            check("rst_evt", {24'd0, if1.evt_cnt}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        expect1(1'b1, 8'd1);
        settle(10);
        check("t1_d", {31'd0, if1.d}, 32'd1);
        drive(1'b0);
        expect1(1'b0, 8'd1);
        settle(10);
        check("t4_d", {31'd0, if1.d}, 32'd0);
        check("t4_evt", {24'd0, if1.evt_cnt}, 32'd1);
        drive(1'b1);
        @(negedge clk);
        drive(1'b0);
        settle(10);
        check("glitch_d", {31'd0, if1.d}, 32'd0);
        check("glitch_evt", {24'd0, if1.evt_cnt}, 32'd1);
        drive(1'b1);
        settle(2);
        drive(1'b0);
        drive(1'b1);
        expect1(1'b1, 8'd2);
        settle(12);
        check("bounce_d", {31'd0, if1.d}, 32'd1);
        check("bounce_evt", {24'd0, if1.evt_cnt}, 32'd2);
        drive(1'b0);
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_wl_d", {31'd0, if1.d}, 32'd0);
        check("arst_wl_evt", {24'd0, if1.evt_cnt}, 32'd0);
        check("arst_wl_fall", {31'd0, if1.fall}, 32'd0);
        drive(1'b1);
        @(negedge clk);
        rst = 1'b0;
        expect1(1'b1, 8'd1);
        settle(10);
        check("arst_wl_relatch", {31'd0, if1.d}, 32'd1);
        drive(1'b0);
        expect1(1'b0, 8'd1);
        settle(10);
        drive(1'b1);
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_wh_evt", {24'd0, if1.evt_cnt}, 32'd0);
        check("arst_wh_d", {31'd0, if1.d}, 32'd0);
        check("arst_wh_rise", {31'd0, if1.rise}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        expect1(1'b1, 8'd1);
        settle(10);
        check("arst_wh_d_after", {31'd0, if1.d}, 32'd1);
        check("arst_wh_evt_after", {24'd0, if1.evt_cnt}, 32'd1);
        drive(1'b0);
        expect1(1'b0, 8'd1);
        settle(10);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if2.din = 1'b1;
            q2.push_back('{cyc: cyc + 6, r: 1'b1, evt: 8'(k % 4)});
            settle(8);
            if2.din = 1'b0;
            q2.push_back('{cyc: cyc + 6, r: 1'b0, evt: 8'(k % 4)});
            settle(7);
        end
        settle(10);
        check("wrap_rises", rise2_n, 32'd5);
        check("wrap_falls", fall2_n, 32'd5);
        check("wrap_final_evt", {30'd0, if2.evt_cnt}, 32'd1);
        check("pending1", q1.size(), 32'd0);
        check("pending2", q2.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
